// File: rtl/usb_tx_packetizer.sv
// usb_tx_packetizer
//   Byte-wide USB-style transmit packetiser. A start request emits a PID
//   byte ({~pid,pid}), then len payload bytes pulled from an upstream
//   valid/ready byte stream, then (optionally) a CRC-16/USB trailer, all on a
//   valid/ready transmit port. After each packet a programmable idle gap is
//   enforced before the next start request is accepted.
//
//   Optional feature macro: USB_TX_CRC16_EN
//     defined   : CRC_LO/CRC_HI trailer appended (wire length 1+len+2)
//     undefined : no CRC logic; wire length 1+len
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-low reset
//   send_data    start request (sampled only while idle)
//   pid[3:0]     packet ID, latched at start
//   len[LEN_W-1:0] payload byte count, latched at start, clamped to MAX_LEN
//   in_data/in_valid/in_ready   upstream payload stream (in_ready combinational)
//   tx_data/tx_valid/tx_ready   transmit port (tx_data/tx_valid registered)
//   busy         high from accepted start until the gap has elapsed
//   done         pulse on the handshake of the final byte of a good packet
//   err_underrun pulse when the payload source starves mid-packet
module usb_tx_packetizer #(
  parameter int MAX_LEN  = 64,
  parameter int LEN_W    = 7,
  parameter int IDLE_GAP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             send_data,
  input  logic [3:0]       pid,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic             err_underrun
);

  localparam int               GAP_W    = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (IDLE_GAP > 0) ? GAP_W'(IDLE_GAP - 1) : '0;
  localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_DATA,
`ifdef USB_TX_CRC16_EN
    S_CRC_LO,
    S_CRC_HI,
`endif
    S_GAP
  } state_t;

  state_t           state_q;
  logic [3:0]       pid_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;      // payload bytes loaded so far
  logic [GAP_W-1:0] gap_q;
  logic             last_q;     // final byte of a good packet sits in the output register
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic             busy_q;

  logic free;
  logic room;

`ifdef USB_TX_CRC16_EN
  logic [15:0] crc_q;

  // Reflected CRC-16 (0xA001), whole byte per cycle, LSB first.
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction
`endif

  assign free = !tx_valid_q || tx_ready;
  assign room = cnt_q < len_q;

  // Status strobes are decoded from registered state so they coincide with
  // the handshake / starvation cycle; reset masks them.
  assign in_ready     = reset && (state_q == S_DATA) && free && room;
  assign err_underrun = reset && (state_q == S_DATA) && free && room && !in_valid;
  assign done         = reset && last_q && tx_valid_q && tx_ready;

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pid_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      last_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_q      <= 16'hFFFF;
`endif
    end else begin
      // A consumed byte drops valid unless a new byte is loaded below.
      if (free) tx_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (send_data) begin
          pid_q   <= pid;
          len_q   <= (len > MAX_L) ? MAX_L : len;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= S_PID;
`ifdef USB_TX_CRC16_EN
          crc_q   <= 16'hFFFF;
`endif
        end
        S_PID: if (free) begin
          tx_data_q  <= {~pid_q, pid_q};
          tx_valid_q <= 1'b1;
          if (len_q != '0) begin
            state_q <= S_DATA;
          end else begin
`ifdef USB_TX_CRC16_EN
            state_q <= S_CRC_LO;
`else
            last_q  <= 1'b1;
            state_q <= S_GAP;
`endif
          end
        end
        S_DATA: if (free) begin
          if (in_valid) begin
            tx_data_q  <= in_data;
            tx_valid_q <= 1'b1;
            cnt_q      <= cnt_q + 1'b1;
`ifdef USB_TX_CRC16_EN
            crc_q      <= crc16_upd(crc_q, in_data);
`endif
            if (cnt_q + 1'b1 == len_q) begin
`ifdef USB_TX_CRC16_EN
              state_q <= S_CRC_LO;
`else
              last_q  <= 1'b1;
              state_q <= S_GAP;
`endif
            end
          end else if (IDLE_GAP == 0) begin
            // underrun: abandon, no trailer, no done
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_GAP;
            gap_q   <= '0;
          end
        end
`ifdef USB_TX_CRC16_EN
        S_CRC_LO: if (free) begin
          tx_data_q  <= ~crc_q[7:0];
          tx_valid_q <= 1'b1;
          state_q    <= S_CRC_HI;
        end
        S_CRC_HI: if (free) begin
          tx_data_q  <= ~crc_q[15:8];
          tx_valid_q <= 1'b1;
          last_q     <= 1'b1;
          state_q    <= S_GAP;
        end
`endif
        S_GAP: begin
          if (last_q) begin
            // drain the final byte; the gap count starts after its handshake
            if (tx_ready) begin
              last_q <= 1'b0;
              gap_q  <= '0;
              if (IDLE_GAP == 0) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end else if (gap_q == GAP_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
module tb_usb_tx_packetizer;
  localparam int MAX_LEN  = 64;
  localparam int LEN_W    = 7;
  localparam int IDLE_GAP = 4;
`ifdef USB_TX_CRC16_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             send_data = 1'b0;
  logic [3:0]       pid = '0;
  logic [LEN_W-1:0] len = '0;
  logic [7:0]       in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b0;
  logic             busy;
  logic             done;
  logic             err_underrun;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  usb_tx_packetizer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .IDLE_GAP(IDLE_GAP)) dut (
    .clk(clk), .reset(reset), .send_data(send_data), .pid(pid), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .err_underrun(err_underrun)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reflected CRC-16/USB reference over payload bytes 0,1,2,...
  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    logic [7:0]  d;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      d = 8'(i);
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int done_n, err_n, done_cyc, err_cyc, first_hs, last_hs, busy_lo, hold_bad, acc;

  // Payload source emits 0,1,2,... ; stall_at<0 means never starve.
  task automatic run_pkt(input logic [3:0] p, input int l, input int stall_at,
                         input bit toggle, input bit resend);
    bit         stalled;
    logic [7:0] held;
    got.delete();
    done_n = 0; err_n = 0; done_cyc = -1; err_cyc = -1;
    first_hs = -1; last_hs = -1; busy_lo = -1; hold_bad = 0; acc = 0;
    stalled = 1'b0; held = '0;
    pid = p; len = LEN_W'(l); send_data = 1'b1; tx_ready = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    send_data = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tx_ready  = !toggle || ((c % 2) == 1);
      in_valid  = (stall_at < 0) || (acc < stall_at);
      in_data   = 8'(acc);
      send_data = resend && (c == 6);
      #1;
      if (stalled && !(tx_valid && tx_data == held)) hold_bad++;
      stalled = tx_valid && !tx_ready;
      held    = tx_data;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        if (first_hs < 0) first_hs = c;
        last_hs = c;
      end
      if (done) begin done_n++; done_cyc = c; end
      if (err_underrun) begin err_n++; err_cyc = c; end
      if (in_valid && in_ready) acc++;
      if (!busy) begin busy_lo = c; break; end
      @(posedge clk); #1;
    end
    send_data = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic build_exp(input logic [3:0] p, input int n, input bit with_crc);
    logic [15:0] crc;
    exp_q.delete();
    exp_q.push_back({~p, p});
    for (int i = 0; i < n; i++) exp_q.push_back(8'(i));
    if (with_crc) begin
      crc = crc_model(n);
      exp_q.push_back(~crc[7:0]);
      exp_q.push_back(~crc[15:8]);
    end
  endtask

  task automatic check_stream(input string tag);
    int bad;
    bad = -1;
    chk({tag, "_nbytes"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (bad < 0 && got[i] !== exp_q[i]) bad = i;
    chk({tag, "_first_bad_byte_idx"}, bad, -1);
  endtask

  initial begin
    // Reset defaults with send_data asserted
    reset = 1'b0; send_data = 1'b1; pid = 4'h3; len = 7'd5; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_underrun, 0);
      chk("rst_in_ready", in_ready, 0);
    end
    chk("rst_tx_data", tx_data, 0);
    send_data = 1'b0; in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // Zero-length packet
    run_pkt(4'h3, 0, -1, 1'b0, 1'b0);
    build_exp(4'h3, 0, CRC_ON);
    check_stream("zlp");
    chk("zlp_first_hs", first_hs, 1);
    chk("zlp_no_bubble", last_hs - first_hs + 1, got.size());
    chk("zlp_done_n", done_n, 1);
    chk("zlp_done_at_last", done_cyc, last_hs);
    chk("zlp_err_n", err_n, 0);
    chk("zlp_gap", busy_lo - last_hs, IDLE_GAP + 1);

    // Full-rate 4-byte payload
    run_pkt(4'h3, 4, -1, 1'b0, 1'b0);
    build_exp(4'h3, 4, CRC_ON);
    check_stream("full");
    chk("full_no_bubble", last_hs - first_hs + 1, got.size());
    chk("full_done_n", done_n, 1);
    chk("full_done_at_last", done_cyc, last_hs);
    chk("full_err_n", err_n, 0);
    chk("full_gap", busy_lo - last_hs, IDLE_GAP + 1);

    // Backpressure: tx_ready toggling
    run_pkt(4'h3, 4, -1, 1'b1, 1'b0);
    build_exp(4'h3, 4, CRC_ON);
    check_stream("bp");
    chk("bp_hold_viol", hold_bad, 0);
    chk("bp_done_n", done_n, 1);
    chk("bp_done_at_last", done_cyc, last_hs);
    chk("bp_gap", busy_lo - last_hs, IDLE_GAP + 1);

    // Underrun after 3 payload bytes
    run_pkt(4'h9, 8, 3, 1'b0, 1'b0);
    build_exp(4'h9, 3, 1'b0);
    check_stream("udr");
    chk("udr_err_n", err_n, 1);
    chk("udr_err_cyc", err_cyc, 4);
    chk("udr_done_n", done_n, 0);
    chk("udr_gap", busy_lo - err_cyc, IDLE_GAP + 1);

    // Clamp len=100 to 64, plus an ignored start request mid-packet
    run_pkt(4'h1, 100, -1, 1'b0, 1'b1);
    build_exp(4'h1, MAX_LEN, CRC_ON);
    check_stream("clamp");
    chk("clamp_done_n", done_n, 1);
    chk("clamp_gap", busy_lo - last_hs, IDLE_GAP + 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("clamp_no_extra_valid", tx_valid, 0);
      chk("clamp_no_extra_busy", busy, 0);
    end

    // Reset during DATA coinciding with a starvation cycle: reset wins
    pid = 4'h5; len = 7'd8; send_data = 1'b1; tx_ready = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    @(posedge clk); #1;
    send_data = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      in_data = in_data + 8'h01;
    end
    chk("mrst_busy_before", busy, 1);
    in_valid = 1'b0; reset = 1'b0;
    #1;
    chk("mrst_err_masked", err_underrun, 0);
    chk("mrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_tx_valid", tx_valid, 0);
    chk("mrst_done", done, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Recovery: short packet after the abandoned one
    run_pkt(4'hA, 1, -1, 1'b0, 1'b0);
    build_exp(4'hA, 1, CRC_ON);
    check_stream("rec");
    chk("rec_done_n", done_n, 1);
    chk("rec_err_n", err_n, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
